// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-master arbiter for the single-port data memory. Each
//               granted access runs IDLE -> ISSUE -> RESP: the owner's
//               address/data/we are presented to the RAM in ISSUE, and the
//               owner is acked with the RAM read data in RESP (one-cycle RAM
//               read latency). Master 0 has fixed priority.
//
//               Optional build macro: DMEM_ARB_STARVE_EN
//                 defined   - a saturating counter tracks consecutive master 0
//                             wins while master 1 waits; at STARVE_LIMIT
//                             master 1 is forced through.
//                 undefined - pure fixed priority, no counter.
//
// Ports       : clk, rst               clock, synchronous active-high reset
//               m0_* / m1_*            req/we/addr/wdata in, ack/rdata out
//               ram_addr/ram_we/ram_din  to the RAM (zero outside ISSUE)
//               ram_dout               RAM read data (one cycle after address)
//               busy                   arbiter not idle
//               owner                  master currently/last granted
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  // master 0
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  // master 1
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  // RAM side
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  // status
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t state_q;
  logic   owner_q;
  logic   owner_d;     // winner of the arbitration evaluated this cycle
  logic   w_force_m1;  // anti-starvation override
  logic   w_issue;
  logic   w_resp;

`ifdef DMEM_ARB_STARVE_EN
  localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] c_limit = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q;

  assign w_force_m1 = m0_req & m1_req & (starve_cnt_q == c_limit);
`else
  logic w_unused_starve_limit;

  assign w_force_m1            = 1'b0;
  assign w_unused_starve_limit = (STARVE_LIMIT > 0);
`endif

  // Master 1 wins when forced or when master 0 is not requesting. The value
  // is only latched when at least one request is present.
  assign owner_d = w_force_m1 | (~m0_req & m1_req);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
`ifdef DMEM_ARB_STARVE_EN
      starve_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (m0_req | m1_req) begin
            owner_q <= owner_d;
            state_q <= S_ISSUE;
          end
`ifdef DMEM_ARB_STARVE_EN
          // Count only m0 wins that made a waiting m1 lose; any m1 win or
          // an arbitration without m1 pending restarts the count.
          if (!m1_req || owner_d) begin
            starve_cnt_q <= '0;
          end else if (starve_cnt_q != c_limit) begin
            starve_cnt_q <= starve_cnt_q + CNT_W'(1);
          end
`endif
        end
        S_ISSUE: begin
          state_q <= S_RESP;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign w_issue = (state_q == S_ISSUE);
  assign w_resp  = (state_q == S_RESP);

  // RAM bus is only driven in ISSUE. The write enable also looks at rst so a
  // reset landing in the ISSUE cycle cannot commit a write.
  assign ram_addr = w_issue ? (owner_q ? m1_addr  : m0_addr)  : '0;
  assign ram_din  = w_issue ? (owner_q ? m1_wdata : m0_wdata) : '0;
  assign ram_we   = w_issue & (owner_q ? m1_we : m0_we) & ~rst;

  // A reset in the RESP cycle swallows the ack.
  assign m0_ack   = w_resp & ~owner_q & ~rst;
  assign m1_ack   = w_resp &  owner_q & ~rst;
  assign m0_rdata = (w_resp & ~owner_q) ? ram_dout : '0;
  assign m1_rdata = (w_resp &  owner_q) ? ram_dout : '0;

  assign busy  = (state_q != S_IDLE);
  assign owner = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter. Masters are queues of
//               transactions; a transaction-level model predicts grant order,
//               bus contents, ack timing and read data per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr, ram_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, ram_din, ram_dout;
  logic          m0_ack, m1_ack, ram_we, busy, owner;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .busy(busy), .owner(owner)
  );

  // Single-port RAM with one-cycle read latency
  logic [DW-1:0] ram [0:1023];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  txn_t          q0[$], q1[$];
  logic [DW-1:0] ref_mem   [0:1023];
  bit            ref_valid [0:1023];

  // model state
  int   cyc = 0;
  int   grant_edge = -100;   // edge at which the current transaction was granted
  int   waits = 0;           // consecutive m0 wins while m1 waited
  bit   cur_owner = 1'b0;
  txn_t t = '0;
  bit   drv_rst = 1'b1, drv_req0 = 1'b0, drv_req1 = 1'b0;
  int   force_rst = 0;
  bit   rst_at_issue = 1'b0, rst_at_resp = 1'b0;

  // observation logs
  int            last_ack0 = -1, last_ack1 = -1, n_ack1 = 0;
  logic [DW-1:0] last_rd0 = '0;
  int            order[$];
  logic [AW-1:0] addr_log[$];

  int n_chk = 0, n_fail = 0;

  function automatic txn_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    txn_t x;
    x.we = we; x.addr = a; x.wdata = d;
    return x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: update model at the edge, drive inputs, check at negedge
  task automatic step();
    int ph;
    bit pick1;
    @(posedge clk);
    cyc++;
    if (drv_rst) begin
      grant_edge = -100; cur_owner = 1'b0; waits = 0;
    end else begin
      ph = cyc - 1 - grant_edge;
      if (ph == 0) begin
        if (t.we) begin ref_mem[t.addr] = t.wdata; ref_valid[t.addr] = 1'b1; end
      end else if (ph == 1) begin
        if (cur_owner) void'(q1.pop_front()); else void'(q0.pop_front());
      end else if (drv_req0 || drv_req1) begin
`ifdef DMEM_ARB_STARVE_EN
        pick1 = !drv_req0 || (drv_req1 && waits >= LIM);
`else
        pick1 = !drv_req0;
`endif
        waits = (!pick1 && drv_req1) ? ((waits < LIM) ? waits + 1 : LIM) : 0;
        cur_owner  = pick1;
        t          = pick1 ? q1[0] : q0[0];
        grant_edge = cyc;
      end else begin
        waits = 0;
      end
    end

    #1;
    ph = cyc - grant_edge;
    drv_rst = 1'b0;
    if (force_rst > 0) begin drv_rst = 1'b1; force_rst--; end
    if (rst_at_issue && ph == 0) begin drv_rst = 1'b1; rst_at_issue = 1'b0; q0.delete(); end
    if (rst_at_resp && ph == 1) begin drv_rst = 1'b1; rst_at_resp = 1'b0; end
    drv_req0 = (q0.size() != 0);
    drv_req1 = (q1.size() != 0);
    rst    = drv_rst;
    m0_req = drv_req0;
    m1_req = drv_req1;
    if (drv_req0) begin m0_we = q0[0].we; m0_addr = q0[0].addr; m0_wdata = q0[0].wdata; end
    if (drv_req1) begin m1_we = q1[0].we; m1_addr = q1[0].addr; m1_wdata = q1[0].wdata; end

    @(negedge clk);
    chk("busy",     32'(busy),     32'(ph == 0 || ph == 1));
    chk("owner",    32'(owner),    32'(cur_owner));
    chk("ram_we",   32'(ram_we),   32'(ph == 0 && t.we && !drv_rst));
    chk("ram_addr", 32'(ram_addr), (ph == 0) ? 32'(t.addr) : 32'd0);
    chk("ram_din",  ram_din,       (ph == 0) ? t.wdata : 32'd0);
    chk("m0_ack",   32'(m0_ack),   32'(ph == 1 && !cur_owner && !drv_rst));
    chk("m1_ack",   32'(m1_ack),   32'(ph == 1 &&  cur_owner && !drv_rst));
    if (ph == 1 && !cur_owner) begin
      if (!t.we && ref_valid[t.addr]) chk("m0_rdata", m0_rdata, ref_mem[t.addr]);
    end else begin
      chk("m0_rdata_idle", m0_rdata, 32'd0);
    end
    if (ph == 1 && cur_owner) begin
      if (!t.we && ref_valid[t.addr]) chk("m1_rdata", m1_rdata, ref_mem[t.addr]);
    end else begin
      chk("m1_rdata_idle", m1_rdata, 32'd0);
    end
    if (ph == 0) addr_log.push_back(ram_addr);
    if (m0_ack === 1'b1) begin last_ack0 = cyc; last_rd0 = m0_rdata; order.push_back(0); end
    if (m1_ack === 1'b1) begin last_ack1 = cyc; n_ack1++; order.push_back(1); end
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || (cyc - grant_edge) <= 1) && n < maxc) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(n < maxc), 32'd1);
    step();
  endtask

  initial begin
    int c0;
    int exp_ord[7];
    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;

    // reset held for two edges, then idle
    force_rst = 1;
    repeat (4) step();

    // single write then read by m0
    q0.push_back(mk(1'b1, 10'h005, 32'hDEADBEEF));
    step(); c0 = cyc;
    drain(20);
    chk("wr_ack_latency", 32'(last_ack0), 32'(c0 + 2));
    q0.push_back(mk(1'b0, 10'h005, 32'h0));
    step(); c0 = cyc;
    drain(20);
    chk("rd_ack_latency", 32'(last_ack0), 32'(c0 + 2));
    chk("rd_data", last_rd0, 32'hDEADBEEF);

    // simultaneous single requests
    addr_log.delete(); order.delete();
    q0.push_back(mk(1'b0, 10'h010, 32'h0));
    q1.push_back(mk(1'b0, 10'h020, 32'h0));
    step(); c0 = cyc;
    drain(30);
    chk("sim_m0_ack", 32'(last_ack0), 32'(c0 + 2));
    chk("sim_m1_ack", 32'(last_ack1), 32'(c0 + 5));
    chk("sim_addr_cnt", 32'(addr_log.size()), 32'd2);
    if (addr_log.size() == 2) begin
      chk("sim_addr0", 32'(addr_log[0]), 32'h010);
      chk("sim_addr1", 32'(addr_log[1]), 32'h020);
    end

    // starvation: six m0 reads back-to-back, one m1 read waiting
    order.delete();
    for (int i = 0; i < 6; i++) q0.push_back(mk(1'b0, AW'(10'h100 + i), 32'h0));
    q1.push_back(mk(1'b0, 10'h200, 32'h0));
`ifdef DMEM_ARB_STARVE_EN
    exp_ord = '{0, 0, 0, 0, 1, 0, 0};
`else
    exp_ord = '{0, 0, 0, 0, 0, 0, 1};
`endif
    drain(100);
    chk("starve_cnt", 32'(order.size()), 32'd7);
    if (order.size() == 7)
      for (int i = 0; i < 7; i++) chk($sformatf("starve_order%0d", i), 32'(order[i]), 32'(exp_ord[i]));

    // reset in the ISSUE cycle of a write
    q0.push_back(mk(1'b1, 10'h003, 32'hA5A50003));
    drain(20);
    last_ack0 = -1;
    rst_at_issue = 1'b1;
    q0.push_back(mk(1'b1, 10'h003, 32'h12345678));
    drain(20);
    chk("rst_issue_noack", 32'(last_ack0), 32'hFFFFFFFF);
    q0.push_back(mk(1'b0, 10'h003, 32'h0));
    drain(20);
    chk("rst_issue_prior", last_rd0, 32'hA5A50003);

    // reset in the RESP cycle: ack swallowed, held request becomes a new txn
    n_ack1 = 0;
    rst_at_resp = 1'b1;
    q1.push_back(mk(1'b0, 10'h005, 32'h0));
    drain(30);
    chk("rst_resp_one_ack", 32'(n_ack1), 32'd1);

    // random traffic from both masters
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0 && q0.size() < 3)
        q0.push_back(mk(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom));
      if ($urandom_range(0, 3) == 0 && q1.size() < 3)
        q1.push_back(mk(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom));
      step();
    end
    drain(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter for the single-port data memory. Master 0 is the CPU-side bus path (RAM address, write enable, write data); master 1 is a secondary requester such as a debug/DMA reader feeding the VGA register/memory view. The arbiter sequences every access as a request → issue → response transaction with a one-cycle RAM read latency. Master 0 has fixed priority, with an optional anti-starvation rule for master 1.

## Interface
Parameters:
- ADDR_W, 10, word-address width (matches 1K-word data memory)
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive m0 wins while m1 waits before m1 is forced through (≥1)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- m0_req  in  1  master 0 request; held until m0_ack
- m0_we  in  1  master 0 write (1) / read (0); stable while m0_req
- m0_addr  in  ADDR_W  master 0 word address; stable while m0_req
- m0_wdata  in  DATA_W  master 0 write data; stable while m0_req
- m0_ack  out  1  one-cycle completion pulse
- m0_rdata  out  DATA_W  read data, valid only while m0_ack
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: same as m0 for master 1
- ram_addr  out  ADDR_W  to RAM address
- ram_we  out  1  to RAM write enable
- ram_din  out  DATA_W  to RAM write data
- ram_dout  in  DATA_W  from RAM; valid the cycle after address is presented
- busy  out  1  state ≠ IDLE
- owner  out  1  master currently granted (0/1)

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: if any req, pick winner, latch into `owner`, go ISSUE; else stay.
- Winner rule: m0 if m0_req, else m1. Exception (with starvation enabled): m1 if both req and starve_cnt == STARVE_LIMIT.
- ISSUE: ram_addr/ram_din = owner's addr/wdata; ram_we = owner's we. Always go RESP.
- RESP: ack of owner = 1; owner's rdata = ram_dout (other master's rdata = 0). Go IDLE.
- Outside ISSUE: ram_we = 0, ram_addr = 0, ram_din = 0.
- Non-owner ack is always 0. Exactly one ack pulse per granted transaction.
- Write transactions also ack in RESP; rdata content is don't-care for writes but is driven as ram_dout.
- starve_cnt, width $clog2(STARVE_LIMIT+1):
  - +1 when m0 wins while m1_req = 1.
  - Cleared when m1 wins, or when m1_req = 0 at an arbitration.
  - Saturates at STARVE_LIMIT.
- Request protocol: a master drops req on the edge ending its ack cycle. A req still high in the following IDLE is a new transaction.

## Timing
- Reset values: state IDLE, owner 0, starve_cnt 0, busy 0, both acks 0, both rdata 0, ram_we 0, ram_addr 0, ram_din 0.
- Latency: req high at edge k (state IDLE) → ISSUE in cycle k+1 → ack in cycle k+2.
- Throughput: one transaction per 3 cycles per arbitration.
- Simultaneous requests: resolved in IDLE only. A request arriving during ISSUE/RESP waits for the next IDLE.
- rst during ISSUE: ram_we is forced 0 that cycle (ram_we = ISSUE & owner_we & ~rst), so no write occurs. State returns to IDLE and no ack is issued.
- rst during RESP: ack is suppressed that cycle.
- Requester dropping req before ack: the transaction still completes and acks (requester violation, not guarded).

## Configuration
- Macro DMEM_ARB_STARVE_EN.
- Defined: starve_cnt and the forced-m1 rule are implemented as above.
- Undefined: pure fixed priority. starve_cnt is not instantiated, and m1 is granted only when m0_req = 0.

## Test plan
- Reset/idle: rst = 1 for 2 cycles, then idle → all outputs 0, busy = 0; ram_we never high.
- Single write then read: m0 writes 0xDEADBEEF to addr 0x005, ack at req+2 cycles; m0 reads 0x005 → m0_ack with m0_rdata = 0xDEADBEEF.
- Simultaneous single requests: m0 reads 0x010 and m1 reads 0x020 in the same cycle → m0 acked at cycle +2, m1 ISSUE at cycle +4, m1 acked at cycle +5; addresses appear on ram_addr in that order.
- Starvation (macro defined, STARVE_LIMIT = 4): m0 requests continuously, m1 holds its request → m1 is granted after exactly 4 m0 transactions, then m0 resumes. With the macro undefined, m1 is never granted while m0_req stays high.
- Reset mid-write: m0 write 0x12345678 to 0x003 with rst asserted in the ISSUE cycle → ram_we stays 0, no ack; a subsequent read of 0x003 returns the prior contents.
